// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_alu : clocked ALU with start/busy/done handshake and iterative        |
// |           shift-add multiply / restoring divide.                          |
// | Optional feature macro: SEQ_ALU_SIGNED_DIV_EN (op D = signed divide).     |
// | Revision: 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             equal,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] c_OP_SLL  = 4'h0;
  localparam logic [3:0] c_OP_SRA  = 4'h1;
  localparam logic [3:0] c_OP_SRL  = 4'h2;
  localparam logic [3:0] c_OP_MUL  = 4'h3;
  localparam logic [3:0] c_OP_DIVU = 4'h4;
  localparam logic [3:0] c_OP_ADD  = 4'h5;
  localparam logic [3:0] c_OP_SUB  = 4'h6;
  localparam logic [3:0] c_OP_AND  = 4'h7;
  localparam logic [3:0] c_OP_OR   = 4'h8;
  localparam logic [3:0] c_OP_XOR  = 4'h9;
  localparam logic [3:0] c_OP_NOR  = 4'hA;
  localparam logic [3:0] c_OP_SLT  = 4'hB;
  localparam logic [3:0] c_OP_SLTU = 4'hC;
`ifdef SEQ_ALU_SIGNED_DIV_EN
  localparam logic [3:0] c_OP_DIV  = 4'hD;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result2;
  logic             r_equal;
  logic             r_done;
  logic             r_eq_pend;
  logic [CW-1:0]    r_cnt;
  // r_hi: product high half / partial remainder; r_lo: multiplier / dividend-quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opa;

  logic             w_is_div;
  logic             w_load_single;
  logic             w_load_mul;
  logic             w_load_div;
  logic             w_fin_mul;
  logic             w_fin_div;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH:0]   w_ddiff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_drem;
  logic [WIDTH-1:0] w_qraw;
  logic [WIDTH-1:0] w_qfix;
  logic [WIDTH-1:0] w_rfix;
  logic [WIDTH-1:0] w_dvd_ld;
  logic [WIDTH-1:0] w_dvs_ld;

  assign result  = r_result;
  assign result2 = r_result2;
  assign equal   = r_equal;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

  assign w_shamt = y[SHW-1:0];

`ifdef SEQ_ALU_SIGNED_DIV_EN
  logic r_negq;
  logic r_negr;
  logic w_sdiv;

  assign w_is_div = (op == c_OP_DIVU) || (op == c_OP_DIV);
  assign w_sdiv   = (op == c_OP_DIV);
  assign w_dvd_ld = (w_sdiv && x[WIDTH-1]) ? -x : x;
  assign w_dvs_ld = (w_sdiv && y[WIDTH-1]) ? -y : y;
  // Divide-by-zero keeps the raw all-ones quotient, so only negate for a nonzero divisor.
  assign w_qfix   = r_negq ? -w_qraw : w_qraw;
  assign w_rfix   = r_negr ? -w_drem : w_drem;
`else
  assign w_is_div = (op == c_OP_DIVU);
  assign w_dvd_ld = x;
  assign w_dvs_ld = y;
  assign w_qfix   = w_qraw;
  assign w_rfix   = w_drem;
`endif

  always_comb begin
    w_alu = '0;
    case (op)
      c_OP_SLL:  w_alu = x << w_shamt;
      c_OP_SRA:  w_alu = $unsigned($signed(x) >>> w_shamt);
      c_OP_SRL:  w_alu = x >> w_shamt;
      c_OP_ADD:  w_alu = x + y;
      c_OP_SUB:  w_alu = x - y;
      c_OP_AND:  w_alu = x & y;
      c_OP_OR:   w_alu = x | y;
      c_OP_XOR:  w_alu = x ^ y;
      c_OP_NOR:  w_alu = ~(x | y);
      c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (x < y)};
      default:   w_alu = '0;
    endcase
  end

  assign w_msum   = {1'b0, r_hi} + ({1'b0, r_opa} & {(WIDTH+1){r_lo[0]}});
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_opa};
  assign w_qbit   = ~w_ddiff[WIDTH];
  assign w_drem   = w_qbit ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
  assign w_qraw   = {r_lo[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_single = 1'b0;
    w_load_mul    = 1'b0;
    w_load_div    = 1'b0;
    w_fin_mul     = 1'b0;
    w_fin_div     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == c_OP_MUL) begin
            w_state_nxt = S_MUL;
            w_load_mul  = 1'b1;
          end else if (w_is_div) begin
            w_state_nxt = S_DIV;
            w_load_div  = 1'b1;
          end else begin
            w_load_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_fin_mul   = 1'b1;
        end
      end
      S_DIV: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_fin_div   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_result2 <= '0;
      r_equal   <= 1'b0;
      r_done    <= 1'b0;
      r_eq_pend <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opa     <= '0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
      r_negq    <= 1'b0;
      r_negr    <= 1'b0;
`endif
    end else begin
      r_done <= w_load_single | w_fin_mul | w_fin_div;
      if (w_load_single) begin
        r_result  <= w_alu;
        r_result2 <= '0;
        r_equal   <= (x == y);
      end
      if (w_load_mul || w_load_div) begin
        r_hi      <= '0;
        r_lo      <= w_load_mul ? y : w_dvd_ld;
        r_opa     <= w_load_mul ? x : w_dvs_ld;
        r_cnt     <= CW'(WIDTH);
        r_eq_pend <= (x == y);
`ifdef SEQ_ALU_SIGNED_DIV_EN
        r_negq    <= w_sdiv && (x[WIDTH-1] ^ y[WIDTH-1]) && (y != '0);
        r_negr    <= w_sdiv && x[WIDTH-1];
`endif
      end
      if (r_state == S_MUL) begin
        r_hi  <= w_msum[WIDTH:1];
        r_lo  <= {w_msum[0], r_lo[WIDTH-1:1]};
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_DIV) begin
        r_hi  <= w_drem;
        r_lo  <= w_qraw;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fin_mul) begin
        r_result  <= {w_msum[0], r_lo[WIDTH-1:1]};
        r_result2 <= w_msum[WIDTH:1];
        r_equal   <= r_eq_pend;
      end
      if (w_fin_div) begin
        r_result  <= w_qfix;
        r_result2 <= w_rfix;
        r_equal   <= r_eq_pend;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_alu : directed self-checking bench for seq_alu at WIDTH = 32.      |
// | Revision: 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_alu;
  localparam int W = 32;

  localparam logic [3:0] c_SLL = 4'h0, c_SRA = 4'h1, c_SRL = 4'h2, c_MUL = 4'h3;
  localparam logic [3:0] c_DIVU = 4'h4, c_ADD = 4'h5, c_SUB = 4'h6, c_AND = 4'h7;
  localparam logic [3:0] c_OR = 4'h8, c_XOR = 4'h9, c_NOR = 4'hA, c_SLT = 4'hB;
  localparam logic [3:0] c_SLTU = 4'hC, c_OPD = 4'hD, c_OPE = 4'hE;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] result;
  logic [W-1:0] result2;
  logic         equal;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .x       (x),
    .y       (y),
    .result  (result),
    .result2 (result2),
    .equal   (equal),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle op; returns in cycle A+1.
  task automatic run_single(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; x = a; y = b;
    tick;
    start = 1'b0;
  endtask

  // Issue a multi-cycle op and wait (bounded) for done; lat counts cycles after A.
  task automatic run_multi(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat);
    start = 1'b1; op = o; x = a; y = b;
    tick;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  initial begin
    int  lat;
    logic saw_done;
    logic all_busy;

    rst = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
    tick; tick; tick;
    chk("rst_result", result, 32'h0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick;
    chk("idle_done", done, 0);
    chk("idle_result2", result2, 32'h0);

    run_single(c_ADD, 32'd5, 32'd7);
    chk("add_done", done, 1);
    chk("add_result", result, 32'd12);
    chk("add_result2", result2, 32'h0);
    chk("add_equal", equal, 0);
    chk("add_busy", busy, 0);
    tick;
    chk("add_done_drop", done, 0);
    chk("add_hold", result, 32'd12);

    // back-to-back accepts
    start = 1'b1; op = c_SRA; x = 32'h8000_0000; y = 32'h24;
    tick;
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_done", done, 1);
    op = c_SLTU; x = 32'd1; y = 32'hFFFF_FFFF;
    tick;
    start = 1'b0;
    chk("sltu_result", result, 32'd1);
    chk("sltu_done", done, 1);

    run_single(c_SLL, 32'd1, 32'd31);
    chk("sll_result", result, 32'h8000_0000);
    run_single(c_SRL, 32'h8000_0000, 32'h21);
    chk("srl_result", result, 32'h4000_0000);
    run_single(c_SUB, 32'd3, 32'd5);
    chk("sub_result", result, 32'hFFFF_FFFE);
    run_single(c_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk("and_result", result, 32'h0F00_0F00);
    run_single(c_OR, 32'hA, 32'h5);
    chk("or_result", result, 32'hF);
    run_single(c_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00);
    chk("nor_result", result, 32'h0000_000F);
    run_single(c_SLT, 32'hFFFF_FFFF, 32'd1);
    chk("slt_result", result, 32'd1);
    run_single(c_OPE, 32'd9, 32'd9);
    chk("ope_result", result, 32'h0);
    chk("ope_equal", equal, 1);
    run_single(c_XOR, 32'h1234, 32'h1234);
    chk("xor_result", result, 32'h0);
    chk("xor_equal", equal, 1);

    // MUL: busy for A+1..A+32, ignored start mid-way, equal held until done
    start = 1'b1; op = c_MUL; x = 32'hFFFF_FFFF; y = 32'd2;
    tick;
    start = 1'b0;
    all_busy = 1'b1;
    saw_done = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || equal !== 1'b1) all_busy = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
      if (i == 5) begin start = 1'b1; op = c_ADD; x = 32'd40; y = 32'd2; end
      if (i == 8) start = 1'b0;
      tick;
    end
    chk("mul_busy_window", all_busy, 1);
    chk("mul_no_early_done", saw_done, 0);
    chk("mul_done", done, 1);
    chk("mul_busy_end", busy, 0);
    chk("mul_result", result, 32'hFFFF_FFFE);
    chk("mul_result2", result2, 32'd1);
    chk("mul_equal", equal, 0);
    tick;
    chk("mul_no_restart", busy, 0);
    chk("mul_hold", result, 32'hFFFF_FFFE);

    run_single(c_ADD, 32'd4, 32'd4);
    chk("add2_result2", result2, 32'h0);

    run_multi(c_DIVU, 32'd100, 32'd7, lat);
    chk("divu_lat", lat, 33);
    chk("divu_q", result, 32'd14);
    chk("divu_r", result2, 32'd2);
    run_multi(c_DIVU, 32'd9, 32'd0, lat);
    chk("div0_lat", lat, 33);
    chk("div0_q", result, 32'hFFFF_FFFF);
    chk("div0_r", result2, 32'd9);

    // reset mid-MUL
    start = 1'b1; op = c_MUL; x = 32'd3; y = 32'd5;
    tick;
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_result", result, 32'h0);
    chk("mrst_result2", result2, 32'h0);
    chk("mrst_equal", equal, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick;
    end
    chk("mrst_no_done", saw_done, 0);
    run_single(c_ADD, 32'd1, 32'd1);
    chk("post_rst_add", result, 32'd2);

`ifdef SEQ_ALU_SIGNED_DIV_EN
    run_multi(c_OPD, 32'hFFFF_FFF9, 32'd2, lat);
    chk("sdiv_lat", lat, 33);
    chk("sdiv_q", result, 32'hFFFF_FFFD);
    chk("sdiv_r", result2, 32'hFFFF_FFFF);
    run_multi(c_OPD, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("sdiv_min_q", result, 32'h8000_0000);
    chk("sdiv_min_r", result2, 32'h0);
    run_multi(c_OPD, 32'hFFFF_FFF7, 32'd0, lat);
    chk("sdiv0_q", result, 32'hFFFF_FFFF);
    chk("sdiv0_r", result2, 32'hFFFF_FFF7);
`else
    run_single(c_OPD, 32'hFFFF_FFF9, 32'd2);
    chk("opd_done", done, 1);
    chk("opd_busy", busy, 0);
    chk("opd_result", result, 32'h0);
    chk("opd_result2", result2, 32'h0);
`endif

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
